rx_deflusher: RTL and testbench

Receive-side counterpart of the transmit flusher in the 25G PCS datapath. It sits between the rx lane deswizzler/fifo output and the upper receive interface. It strips the flush sequence (`ESC_PACK` followed by `FLUSH_PACK`) inserted by the transmitter during idle periods. It also collapses an escaped data word (`ESC_PACK` followed by `ESC_PACK`) back into a single `ESC_PACK` data word, so the upper layer sees exactly the original tx data stream.

---
 rtl/rx_deflusher_if.sv | 34 +++
 rtl/rx_deflusher.sv | 66 ++++++
 tb/tb_rx_deflusher.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rx_deflusher_if.sv
// rx_deflusher_if: receive datapath bundle between the lane fifo and the upper receive layer
// Ports (slave = deflusher side):
//   in_enable        clock enable, no input consumed when low
//   in_rxdata        192-bit received word
//   in_rxdata_valid  in_rxdata carries a word
//   out_rxdata       de-flushed data word, held while not valid
//   out_rxdata_valid one-cycle qualifier for out_rxdata
//   out_flush        one-cycle pulse per removed flush sequence
//   out_esc_err      one-cycle pulse for an escape followed by an illegal word
//   out_flush_cnt    saturating count of removed flush sequences
`ifndef ESC_PACK
`define ESC_PACK {24{8'hE5}}
`endif
`ifndef FLUSH_PACK
`define FLUSH_PACK {24{8'hF1}}
`endif
interface rx_deflusher_if;
  logic         in_enable;
  logic [191:0] in_rxdata;
  logic         in_rxdata_valid;
  logic [191:0] out_rxdata;
  logic         out_rxdata_valid;
  logic         out_flush;
  logic         out_esc_err;
  logic [15:0]  out_flush_cnt;
  modport master (
    output in_enable, in_rxdata, in_rxdata_valid,
    input  out_rxdata, out_rxdata_valid, out_flush, out_esc_err, out_flush_cnt
  );
  modport slave (
    input  in_enable, in_rxdata, in_rxdata_valid,
    output out_rxdata, out_rxdata_valid, out_flush, out_esc_err, out_flush_cnt
  );
endinterface

// File: rtl/rx_deflusher.sv
// rx_deflusher: strips ESC/FLUSH sequences and collapses ESC/ESC back to one ESC data word
// Ports:
//   clk      datapath clock
//   reset_n  asynchronous active-low reset
//   rx       rx_deflusher_if slave: enable/word/valid in, data/valid/flush/esc_err/flush_cnt out
module rx_deflusher (
  input  logic           clk,
  input  logic           reset_n,
  rx_deflusher_if.slave  rx
);
  typedef enum logic {S_NORMAL = 1'b0, S_GOTESC = 1'b1} state_t;
  state_t       state_q;
  logic [191:0] data_q;
  logic         valid_q;
  logic         flush_q;
  logic         err_q;
  logic [15:0]  flush_cnt_q;
  logic [15:0]  flush_cnt_d;
  logic         accept;
  logic         is_esc;
  logic         is_flush;
  assign accept      = rx.in_enable && rx.in_rxdata_valid;
  assign is_esc      = rx.in_rxdata == `ESC_PACK;
  assign is_flush    = rx.in_rxdata == `FLUSH_PACK;
  assign flush_cnt_d = flush_cnt_q + {15'd0, flush_cnt_q != 16'hFFFF};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= S_NORMAL;
      data_q      <= '0;
      valid_q     <= 1'b0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      if (accept)
        case (state_q)
          S_NORMAL:
            if (is_esc) state_q <= S_GOTESC;
            else begin
              data_q  <= rx.in_rxdata;
              valid_q <= 1'b1;
            end
          S_GOTESC: begin
            state_q <= S_NORMAL;
            if (is_flush) begin
              flush_q     <= 1'b1;
              flush_cnt_q <= flush_cnt_d;
            end else begin
              // an escaped ESC is the word itself; any other word drops the escape and is flagged
              data_q  <= rx.in_rxdata;
              valid_q <= 1'b1;
              err_q   <= !is_esc;
            end
          end
          default: state_q <= S_NORMAL;
        endcase
    end
  assign rx.out_rxdata       = data_q;
  assign rx.out_rxdata_valid = valid_q;
  assign rx.out_flush        = flush_q;
  assign rx.out_esc_err      = err_q;
  assign rx.out_flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_rx_deflusher.sv
// tb_rx_deflusher: directed self-checking bench for rx_deflusher
`ifndef ESC_PACK
`define ESC_PACK {24{8'hE5}}
`endif
`ifndef FLUSH_PACK
`define FLUSH_PACK {24{8'hF1}}
`endif
module tb_rx_deflusher;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  localparam logic [191:0] ESC = `ESC_PACK;
  localparam logic [191:0] FLU = `FLUSH_PACK;
  localparam logic [191:0] WA  = 192'h1111_2222_3333;
  localparam logic [191:0] WB  = {64'hDEAD_BEEF_0000_0001, 128'h0};
  localparam logic [191:0] WC  = {192{1'b1}};
  localparam logic [191:0] W5  = 192'h5;
  rx_deflusher_if rx ();
  rx_deflusher dut (.clk(clk), .reset_n(reset_n), .rx(rx.slave));
  always #5 clk = ~clk;
  task automatic step(input logic en, input logic v, input logic [191:0] w);
    rx.in_enable       = en;
    rx.in_rxdata_valid = v;
    rx.in_rxdata       = w;
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic test_reset;
    #1 reset_n = 1'b0;
    #2;
    chk("reset data", rx.out_rxdata, 0);
    chk("reset valid", 192'(rx.out_rxdata_valid), 0);
    chk("reset flush", 192'(rx.out_flush), 0);
    chk("reset err", 192'(rx.out_esc_err), 0);
    chk("reset cnt", 192'(rx.out_flush_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic test_plain;
    step(1, 1, WA);
    chk("plain A data", rx.out_rxdata, WA);
    chk("plain A valid", 192'(rx.out_rxdata_valid), 1);
    step(1, 1, WB);
    chk("plain B data", rx.out_rxdata, WB);
    chk("plain B valid", 192'(rx.out_rxdata_valid), 1);
    step(1, 1, WC);
    chk("plain C data", rx.out_rxdata, WC);
    chk("plain C flush", 192'(rx.out_flush), 0);
    step(1, 0, WA);
    chk("plain idle valid", 192'(rx.out_rxdata_valid), 0);
    chk("plain hold data", rx.out_rxdata, WC);
  endtask
  task automatic test_flush_gap;
    step(1, 1, ESC);
    chk("fgap esc valid", 192'(rx.out_rxdata_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, FLU);
      chk("fgap gap valid", 192'(rx.out_rxdata_valid), 0);
      chk("fgap gap flush", 192'(rx.out_flush), 0);
    end
    step(1, 1, FLU);
    chk("fgap flush pulse", 192'(rx.out_flush), 1);
    chk("fgap flush valid", 192'(rx.out_rxdata_valid), 0);
    chk("fgap cnt", 192'(rx.out_flush_cnt), 1);
    step(1, 0, 0);
    chk("fgap pulse end", 192'(rx.out_flush), 0);
  endtask
  task automatic test_escaped;
    step(1, 1, WB);
    chk("esc D1 data", rx.out_rxdata, WB);
    step(1, 1, ESC);
    chk("esc first valid", 192'(rx.out_rxdata_valid), 0);
    step(1, 1, ESC);
    chk("esc out data", rx.out_rxdata, ESC);
    chk("esc out valid", 192'(rx.out_rxdata_valid), 1);
    chk("esc out err", 192'(rx.out_esc_err), 0);
    step(1, 1, WA);
    chk("esc D2 data", rx.out_rxdata, WA);
    chk("esc D2 valid", 192'(rx.out_rxdata_valid), 1);
    chk("esc D2 flush", 192'(rx.out_flush), 0);
  endtask
  task automatic test_esc_err;
    step(1, 1, ESC);
    step(1, 1, W5);
    chk("err data", rx.out_rxdata, W5);
    chk("err valid", 192'(rx.out_rxdata_valid), 1);
    chk("err pulse", 192'(rx.out_esc_err), 1);
    step(1, 1, FLU);
    chk("err flush as data", rx.out_rxdata, FLU);
    chk("err flush valid", 192'(rx.out_rxdata_valid), 1);
    chk("err pulse end", 192'(rx.out_esc_err), 0);
    chk("err no flush", 192'(rx.out_flush), 0);
    chk("err cnt kept", 192'(rx.out_flush_cnt), 1);
  endtask
  task automatic test_enable_reset;
    step(1, 1, WC);
    step(0, 1, WB);
    chk("en0 clears valid", 192'(rx.out_rxdata_valid), 0);
    chk("en0 holds data", rx.out_rxdata, WC);
    step(1, 1, ESC);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, FLU);
      chk("en0 flush ignored", 192'(rx.out_flush), 0);
      chk("en0 valid", 192'(rx.out_rxdata_valid), 0);
    end
    step(1, 1, FLU);
    chk("en1 flush pulse", 192'(rx.out_flush), 1);
    chk("en1 cnt", 192'(rx.out_flush_cnt), 2);
    step(1, 1, ESC);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst data", rx.out_rxdata, 0);
    chk("midrst cnt", 192'(rx.out_flush_cnt), 0);
    chk("midrst valid", 192'(rx.out_rxdata_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, FLU);
    chk("postrst flush data", rx.out_rxdata, FLU);
    chk("postrst flush valid", 192'(rx.out_rxdata_valid), 1);
    chk("postrst no pulse", 192'(rx.out_flush), 0);
  endtask
  task automatic test_back_to_back;
    step(1, 1, ESC);
    chk("b2b e1 valid", 192'(rx.out_rxdata_valid), 0);
    step(1, 1, ESC);
    chk("b2b e2 valid", 192'(rx.out_rxdata_valid), 1);
    chk("b2b e2 data", rx.out_rxdata, ESC);
    step(1, 1, ESC);
    chk("b2b e3 valid", 192'(rx.out_rxdata_valid), 0);
    step(1, 1, ESC);
    chk("b2b e4 valid", 192'(rx.out_rxdata_valid), 1);
    chk("b2b e4 data", rx.out_rxdata, ESC);
  endtask
  task automatic test_saturation;
    force dut.flush_cnt_q = 16'hFFFE;
    #1 release dut.flush_cnt_q;
    step(1, 1, ESC);
    step(1, 1, FLU);
    chk("sat reach max", 192'(rx.out_flush_cnt), 16'hFFFF);
    step(1, 1, ESC);
    step(1, 1, FLU);
    chk("sat hold max", 192'(rx.out_flush_cnt), 16'hFFFF);
    chk("sat still pulses", 192'(rx.out_flush), 1);
  endtask
  initial begin
    rx.in_enable       = 1'b0;
    rx.in_rxdata_valid = 1'b0;
    rx.in_rxdata       = '0;
    test_reset();
    test_plain();
    test_flush_gap();
    test_escaped();
    test_esc_err();
    test_enable_reset();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
